// File: rtl/lcd_clock_display_ctrl.sv
// rtl/lcd_clock_display_ctrl.sv - HD44780 4-bit init and HH:MM:SS frame sequencer
// Every step runs a cycle counter from 0; nibble slots are launched at counts 0 and T_NIB.
module lcd_clock_display_ctrl #(
   parameter int         T_PWRUP   = 750000,
   parameter int         T_INIT1   = 205000,
   parameter int         T_INIT2   = 5000,
   parameter int         T_CMD     = 2000,
   parameter int         T_CLR     = 82000,
   parameter int         T_E       = 12,
   parameter int         T_NIB     = 50,
   parameter logic [6:0] DDRAM_POS = 7'h00
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [23:0] digits_i,
   input  logic        upd_i,
   output logic        ready_o,
   output logic        frame_done_o,
   output logic [3:0]  lcd_db_o,
   output logic        lcd_e_o,
   output logic        lcd_rs_o,
   output logic        lcd_rw_o
);
   localparam int T_BYTE = T_NIB + ((T_CLR > T_CMD) ? T_CLR : T_CMD);
   localparam int T_M1   = (T_PWRUP > T_INIT1) ? T_PWRUP : T_INIT1;
   localparam int T_MAX  = (T_M1 > T_BYTE) ? T_M1 : T_BYTE;
   localparam int CW     = $clog2(T_MAX + 1);
   localparam logic [CW-1:0] C_ONE  = CW'(1);
   localparam logic [CW-1:0] C_E    = CW'(T_E);
   localparam logic [CW-1:0] C_NIB  = CW'(T_NIB);
   localparam logic [CW-1:0] C_NIB1 = CW'(T_NIB + 1);
   localparam logic [CW-1:0] C_NIBE = CW'(T_NIB + T_E);

   typedef enum logic [3:0] {
      S_PWRUP, S_INIT_A, S_INIT_B, S_INIT_C, S_INIT_D, S_CFG, S_IDLE, S_ADDR, S_CHAR
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [23:0]     shadow_q, shadow_d;
   logic            pending_q, pending_d;
   logic [3:0]      db_q, db_d;
   logic            rs_q, rs_d, e_q, e_d, done_q, done_d;
   logic [3:0]      dig_w;
   logic [7:0]      code_w;
   logic [CW-1:0]   last_w;
   logic            is_slot_w, is_byte_w;

   // What the current step sends and how long it lasts.
   always_comb begin
      case (idx_q)
         3'd0:    dig_w = shadow_q[23:20];
         3'd1:    dig_w = shadow_q[19:16];
         3'd3:    dig_w = shadow_q[15:12];
         3'd4:    dig_w = shadow_q[11:8];
         3'd6:    dig_w = shadow_q[7:4];
         3'd7:    dig_w = shadow_q[3:0];
         default: dig_w = 4'h0;
      endcase
      code_w    = 8'h00;
      is_slot_w = 1'b1;
      is_byte_w = 1'b0;
      last_w    = CW'(T_NIB + T_CMD - 1);
      case (state_q)
         S_PWRUP: begin
            is_slot_w = 1'b0;
            last_w    = CW'(T_PWRUP - 1);
         end
         S_INIT_A: begin
            code_w = 8'h30;
            last_w = CW'(T_INIT1 - 1);
         end
         S_INIT_B: begin
            code_w = 8'h30;
            last_w = CW'(T_INIT2 - 1);
         end
         S_INIT_C: begin
            code_w = 8'h30;
            last_w = CW'(T_CMD - 1);
         end
         S_INIT_D: begin
            code_w = 8'h20;
            last_w = CW'(T_CMD - 1);
         end
         S_CFG: begin
            is_byte_w = 1'b1;
            case (idx_q[1:0])
               2'd0:    code_w = 8'h28;
               2'd1:    code_w = 8'h06;
               2'd2:    code_w = 8'h0C;
               default: code_w = 8'h01;
            endcase
            if (idx_q[1:0] == 2'd3) last_w = CW'(T_NIB + T_CLR - 1);
         end
         S_ADDR: begin
            is_byte_w = 1'b1;
            code_w    = {1'b1, DDRAM_POS};
         end
         S_CHAR: begin
            is_byte_w = 1'b1;
            code_w    = (idx_q == 3'd2 || idx_q == 3'd5) ? 8'h3A : {4'h3, dig_w};
         end
         default: is_slot_w = 1'b0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      shadow_d  = shadow_q;
      pending_d = pending_q;
      db_d      = db_q;
      rs_d      = rs_q;
      done_d    = 1'b0;
      e_d       = 1'b0;
      if (is_slot_w) begin
         e_d = (cnt_q >= C_ONE && cnt_q <= C_E) ||
               (is_byte_w && cnt_q >= C_NIB1 && cnt_q <= C_NIBE);
         if (cnt_q == '0) begin
            db_d = code_w[7:4];
            rs_d = (state_q == S_CHAR);
         end else if (is_byte_w && cnt_q == C_NIB) begin
            db_d = code_w[3:0];
         end
      end
      if (upd_i && state_q != S_IDLE) pending_d = 1'b1;
      if (state_q == S_IDLE) begin
         if (upd_i) begin
            state_d  = S_ADDR;
            shadow_d = digits_i;
            cnt_d    = '0;
         end
      end else if (cnt_q == last_w) begin
         cnt_d = '0;
         case (state_q)
            S_PWRUP:  state_d = S_INIT_A;
            S_INIT_A: state_d = S_INIT_B;
            S_INIT_B: state_d = S_INIT_C;
            S_INIT_C: state_d = S_INIT_D;
            S_INIT_D: begin
               state_d = S_CFG;
               idx_d   = 3'd0;
            end
            S_CFG: begin
               idx_d = (idx_q[1:0] == 2'd3) ? 3'd0 : idx_q + 3'd1;
               if (idx_q[1:0] == 2'd3) state_d = S_IDLE;
            end
            S_ADDR: begin
               state_d = S_CHAR;
               idx_d   = 3'd0;
            end
            S_CHAR: begin
               idx_d = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
                  done_d = 1'b1;
                  // A request arriving on the final cycle still chains the next frame.
                  if (pending_q || upd_i) begin
                     state_d   = S_ADDR;
                     shadow_d  = digits_i;
                     pending_d = 1'b0;
                  end else begin
                     state_d = S_IDLE;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end else begin
         cnt_d = cnt_q + C_ONE;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_PWRUP;
         cnt_q     <= '0;
         idx_q     <= 3'd0;
         shadow_q  <= 24'h0;
         pending_q <= 1'b0;
         db_q      <= 4'h0;
         rs_q      <= 1'b0;
         e_q       <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
         db_q      <= db_d;
         rs_q      <= rs_d;
         e_q       <= e_d;
         done_q    <= done_d;
      end
   end

   assign ready_o      = (state_q == S_IDLE);
   assign frame_done_o = done_q;
   assign lcd_db_o     = db_q;
   assign lcd_e_o      = e_q;
   assign lcd_rs_o     = rs_q;
   assign lcd_rw_o     = 1'b0;

endmodule

// File: tb/tb_lcd_clock_display_ctrl.sv
// tb/tb_lcd_clock_display_ctrl.sv - randomized bench for lcd_clock_display_ctrl
// Expected nibble stream is built from byte values and wait times, compared strobe by strobe.
module tb_lcd_clock_display_ctrl;
   localparam int T_PWRUP = 20, T_INIT1 = 30, T_INIT2 = 10, T_CMD = 8, T_CLR = 16;
   localparam int T_E = 3, T_NIB = 6;
   localparam int POS = 0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [23:0] digits = 24'h0;
   logic        upd = 1'b0;
   logic        ready_o, frame_done_o, lcd_e_o, lcd_rs_o, lcd_rw_o;
   logic [3:0]  lcd_db_o;

   lcd_clock_display_ctrl #(
      .T_PWRUP(T_PWRUP), .T_INIT1(T_INIT1), .T_INIT2(T_INIT2), .T_CMD(T_CMD),
      .T_CLR(T_CLR), .T_E(T_E), .T_NIB(T_NIB), .DDRAM_POS(7'(POS))
   ) dut (
      .clk_i(clk), .rst_i(rst), .digits_i(digits), .upd_i(upd),
      .ready_o(ready_o), .frame_done_o(frame_done_o), .lcd_db_o(lcd_db_o),
      .lcd_e_o(lcd_e_o), .lcd_rs_o(lcd_rs_o), .lcd_rw_o(lcd_rw_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0, n_pass = 0;
   int got_nib[$], got_rs[$], got_gap[$];
   int exp_nib[$], exp_rs[$], exp_gap[$];
   int next_gap, exp_frames, exp_rdy;
   int done_cnt, rdy_rise, rw_viol, viol, hi, cyc, last_rise;
   bit mon_en = 1'b0;
   bit pe, prs, pready;
   logic [3:0] pdb;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Strobe monitor: records E rises, checks width and bus stability around each strobe.
   always @(negedge clk) begin
      cyc++;
      if (!mon_en) begin
         hi = 0;
         viol = 0;
         last_rise = cyc;
      end else begin
         if (lcd_rw_o !== 1'b0) rw_viol++;
         if (lcd_e_o || pe)
            if (lcd_db_o !== pdb || lcd_rs_o !== prs) viol++;
         if (lcd_e_o && !pe) begin
            got_nib.push_back(int'(lcd_db_o));
            got_rs.push_back(int'(lcd_rs_o));
            got_gap.push_back(cyc - last_rise);
            last_rise = cyc;
            hi = 1;
         end else if (lcd_e_o) begin
            hi++;
         end else if (pe) begin
            check("e_width", hi, T_E);
            check("db_rs_hold", viol, 0);
            viol = 0;
         end
         if (frame_done_o) done_cnt++;
         if (ready_o && !pready) rdy_rise++;
      end
      pe = lcd_e_o;
      pdb = lcd_db_o;
      prs = lcd_rs_o;
      pready = ready_o;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_upd();
      upd = 1'b1;
      tick(1);
      upd = 1'b0;
   endtask

   task automatic push_nib(input int n, input int r, input int g);
      exp_nib.push_back(n);
      exp_rs.push_back(r);
      exp_gap.push_back(g);
   endtask

   task automatic push_byte(input int b, input int r, input int g, input int w);
      push_nib(b / 16, r, g);
      push_nib(b % 16, r, T_NIB);
      next_gap = w;
   endtask

   task automatic model_init();
      push_nib(3, 0, -1);
      push_nib(3, 0, T_INIT1);
      push_nib(3, 0, T_INIT2);
      push_nib(2, 0, T_CMD);
      next_gap = T_CMD;
      push_byte('h28, 0, next_gap, T_CMD);
      push_byte('h06, 0, next_gap, T_CMD);
      push_byte('h0C, 0, next_gap, T_CMD);
      push_byte('h01, 0, next_gap, T_CLR);
      exp_rdy++;
   endtask

   task automatic model_frame(input logic [23:0] d, input bit chained);
      int ch, k;
      push_byte('h80 + POS, 0, chained ? next_gap : -1, T_CMD);
      for (int i = 0; i < 8; i++) begin
         if (i == 2 || i == 5) begin
            ch = 'h3A;
         end else begin
            k = i - i / 3;
            ch = 'h30 + int'((d >> (4 * (5 - k))) & 24'hF);
         end
         push_byte(ch, 1, next_gap, T_CMD);
      end
      exp_frames++;
      if (!chained) exp_rdy++;
   endtask

   task automatic wait_ready(input string tag);
      int k = 0;
      while (!ready_o && k < 3000) begin
         tick(1);
         k++;
      end
      check({tag, "_ready"}, int'(ready_o), 1);
   endtask

   task automatic compare_stream(input string tag);
      check({tag, "_len"}, got_nib.size(), exp_nib.size());
      for (int i = 0; i < exp_nib.size() && i < got_nib.size(); i++) begin
         check($sformatf("%s_nib%0d", tag, i), got_nib[i], exp_nib[i]);
         check($sformatf("%s_rs%0d", tag, i), got_rs[i], exp_rs[i]);
         if (exp_gap[i] >= 0) check($sformatf("%s_gap%0d", tag, i), got_gap[i], exp_gap[i]);
      end
      check({tag, "_frames"}, done_cnt, exp_frames);
      check({tag, "_ready_rises"}, rdy_rise, exp_rdy);
      got_nib.delete(); got_rs.delete(); got_gap.delete();
      exp_nib.delete(); exp_rs.delete(); exp_gap.delete();
   endtask

   task automatic clear_model();
      got_nib.delete(); got_rs.delete(); got_gap.delete();
      exp_nib.delete(); exp_rs.delete(); exp_gap.delete();
      done_cnt = 0; rdy_rise = 0; exp_frames = 0; exp_rdy = 0;
   endtask

   initial begin
      logic [23:0] d;
      int mode, np;
      bit found;
      clear_model();
      rw_viol = 0;
      tick(2);
      check("rst_db", int'(lcd_db_o), 0);
      check("rst_e", int'(lcd_e_o), 0);
      check("rst_rs", int'(lcd_rs_o), 0);
      check("rst_rw", int'(lcd_rw_o), 0);
      check("rst_ready", int'(ready_o), 0);
      check("rst_done", int'(frame_done_o), 0);
      rst = 1'b0;
      mon_en = 1'b1;
      model_init();
      wait_ready("init");
      tick(5);
      compare_stream("init");

      digits = 24'h123456;
      pulse_upd();
      model_frame(24'h123456, 0);
      wait_ready("t2");
      tick(5);
      compare_stream("t2");

      digits = 24'h654321;
      pulse_upd();
      model_frame(24'h654321, 0);
      tick(10); pulse_upd();
      tick(20); pulse_upd();
      tick(20); pulse_upd();
      model_frame(24'h654321, 1);
      wait_ready("t3");
      tick(20);
      compare_stream("t3");

      digits = 24'h123456;
      pulse_upd();
      digits = 24'h235959;
      model_frame(24'h123456, 0);
      tick(5);
      pulse_upd();
      model_frame(24'h235959, 1);
      wait_ready("t4");
      tick(5);
      compare_stream("t4");

      for (int it = 0; it < 12; it++) begin
         d = 24'($urandom);
         digits = d;
         pulse_upd();
         model_frame(d, 0);
         digits = 24'($urandom);
         mode = $urandom_range(0, 2);
         if (mode > 0) begin
            np = $urandom_range(1, 3);
            for (int p = 0; p < np; p++) begin
               tick($urandom_range(3, 30));
               pulse_upd();
               d = 24'($urandom);
               digits = d;
            end
            model_frame(d, 1);
         end
         wait_ready($sformatf("rnd%0d", it));
         tick($urandom_range(1, 6));
         compare_stream($sformatf("rnd%0d", it));
      end

      digits = 24'h101010;
      pulse_upd();
      tick(4);
      pulse_upd();
      found = 1'b0;
      for (int k = 0; k < 500 && !found; k++) begin
         if (lcd_e_o && lcd_rs_o) found = 1'b1;
         else tick(1);
      end
      check("t5_char_strobe_seen", int'(found), 1);
      rst = 1'b1;
      mon_en = 1'b0;
      tick(1);
      check("t5_e_low", int'(lcd_e_o), 0);
      check("t5_ready", int'(ready_o), 0);
      tick(1);
      clear_model();
      rst = 1'b0;
      mon_en = 1'b1;
      model_init();
      wait_ready("t5_init");
      tick(60);
      compare_stream("t5");
      check("rw_zero", rw_viol, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
